matmul_sequencer: RTL and testbench

- Top-level controller for one 2x2 (N x N) systolic matmul pass.
- On a start pulse it:
  - reads N weight rows from unified memory and drives the array's weight latches;
  - reads N activation rows into the activation skew/setup stage;
  - clears the accumulators, asserts the setup-stage valid for the skew window and waits out the array drain;
  - writes N result rows back to memory, then pulses done.
- Sits between the instruction/host interface and the memory, input-setup and systolic-array blocks.

---
 rtl/matmul_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_matmul_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_sequencer.sv
// Sequencer for one NxN systolic matmul pass: load W, load A, feed, drain, write.
// Define MATMUL_SEQ_PERF_EN to add cycle_count/stall_count perf outputs.
module matmul_sequencer #(
  parameter int N         = 2,
  parameter int ADDR_W    = 8,
  parameter int DRAIN_CYC = 3,
  localparam int RW = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_w,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_out,
  input  logic              mem_stall,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  output logic              w_load_en,
  output logic              a_load_en,
  output logic [RW-1:0]     load_row,
  output logic              sa_clear,
  output logic              setup_valid,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [RW-1:0]     out_row
`ifdef MATMUL_SEQ_PERF_EN
  ,
  output logic [31:0]       cycle_count,
  output logic [31:0]       stall_count
`endif
);

  localparam int CW = $clog2(2 * N + DRAIN_CYC + 1);
  localparam logic [CW-1:0] LAST_ROW  = CW'(N - 1);
  localparam logic [CW-1:0] LAST_FEED = CW'(2 * N - 2);
  localparam logic [CW-1:0] LAST_DRN  = CW'(DRAIN_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD_W, LOAD_A, SYNC, FEED, DRAIN, WRITE, DONE
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] bw_q, bw_d, ba_q, ba_d, bo_q, bo_d;
  logic busy_q, busy_d, done_q, done_d;
  logic rd_en_q, rd_en_d, wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic w_ld_q, w_ld_d, a_ld_q, a_ld_d;
  logic [RW-1:0] ld_row_q, ld_row_d, out_row_q, out_row_d;
  logic clr_q, clr_d, sv_q, sv_d;
  logic issued, last_row, rd_st_d, mem_st_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bw_d    = bw_q;
    ba_d    = ba_q;
    bo_d    = bo_q;
    // a memory row only advances once its access has actually gone out
    issued   = rd_en_q | wr_en_q;
    last_row = (cnt_q == LAST_ROW);
    unique case (state_q)
      IDLE: if (start) begin
        state_d = LOAD_W;
        cnt_d   = '0;
        bw_d    = base_w;
        ba_d    = base_a;
        bo_d    = base_out;
      end
      LOAD_W: if (issued) begin
        state_d = last_row ? LOAD_A : LOAD_W;
        cnt_d   = last_row ? '0 : cnt_q + CW'(1);
      end
      LOAD_A: if (issued) begin
        state_d = last_row ? SYNC : LOAD_A;
        cnt_d   = last_row ? '0 : cnt_q + CW'(1);
      end
      SYNC: begin
        state_d = FEED;
        cnt_d   = '0;
      end
      FEED: begin
        state_d = (cnt_q == LAST_FEED) ? DRAIN : FEED;
        cnt_d   = (cnt_q == LAST_FEED) ? '0 : cnt_q + CW'(1);
      end
      DRAIN: begin
        state_d = (cnt_q == LAST_DRN) ? WRITE : DRAIN;
        cnt_d   = (cnt_q == LAST_DRN) ? '0 : cnt_q + CW'(1);
      end
      WRITE: if (issued) begin
        state_d = last_row ? DONE : WRITE;
        cnt_d   = last_row ? '0 : cnt_q + CW'(1);
      end
      DONE: state_d = IDLE;
    endcase

    rd_st_d  = (state_d == LOAD_W) || (state_d == LOAD_A);
    mem_st_d = rd_st_d || (state_d == WRITE);
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
    clr_d    = (state_d == SYNC);
    sv_d     = (state_d == FEED);
    rd_en_d  = rd_st_d && !mem_stall;
    wr_en_d  = (state_d == WRITE) && !mem_stall;

    rd_addr_d = rd_addr_q;
    unique case (1'b1)
      state_d == LOAD_W: rd_addr_d = bw_d + ADDR_W'(cnt_d);
      state_d == LOAD_A: rd_addr_d = ba_d + ADDR_W'(cnt_d);
      default:           rd_addr_d = rd_addr_q;
    endcase

    wr_addr_d = wr_addr_q;
    out_row_d = out_row_q;
    if (state_d == WRITE) begin
      wr_addr_d = bo_d + ADDR_W'(cnt_d);
      out_row_d = cnt_d[RW-1:0];
    end

    // load strobes trail the read by one cycle regardless of state
    w_ld_d   = rd_en_q && (state_q == LOAD_W);
    a_ld_d   = rd_en_q && (state_q == LOAD_A);
    ld_row_d = rd_en_q ? cnt_q[RW-1:0] : ld_row_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bw_q      <= '0;
      ba_q      <= '0;
      bo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      w_ld_q    <= 1'b0;
      a_ld_q    <= 1'b0;
      ld_row_q  <= '0;
      out_row_q <= '0;
      clr_q     <= 1'b0;
      sv_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bw_q      <= bw_d;
      ba_q      <= ba_d;
      bo_q      <= bo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      w_ld_q    <= w_ld_d;
      a_ld_q    <= a_ld_d;
      ld_row_q  <= ld_row_d;
      out_row_q <= out_row_d;
      clr_q     <= clr_d;
      sv_q      <= sv_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign mem_rd_en   = rd_en_q;
  assign mem_rd_addr = rd_addr_q;
  assign w_load_en   = w_ld_q;
  assign a_load_en   = a_ld_q;
  assign load_row    = ld_row_q;
  assign sa_clear    = clr_q;
  assign setup_valid = sv_q;
  assign mem_wr_en   = wr_en_q;
  assign mem_wr_addr = wr_addr_q;
  assign out_row     = out_row_q;

`ifdef MATMUL_SEQ_PERF_EN
  logic [31:0] pc_q, pc_d, sc_q, sc_d, sc_base;
  logic [31:0] cyc_q, cyc_d, stl_q, stl_d;
  logic stall_now;

  always_comb begin
    stall_now = mem_st_d && mem_stall;
    pc_d = (state_q == IDLE) ? '0 :
           (pc_q == '1) ? pc_q : pc_q + 32'd1;
    sc_base = (state_q == IDLE) ? '0 : sc_q;
    sc_d = (stall_now && sc_base != '1) ?
           sc_base + 32'd1 : sc_base;
    cyc_d = cyc_q;
    stl_d = stl_q;
    if (state_q == DONE) begin
      cyc_d = (pc_q == '1) ? pc_q : pc_q + 32'd1;
      stl_d = sc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= '0;
      sc_q  <= '0;
      cyc_q <= '0;
      stl_q <= '0;
    end else begin
      pc_q  <= pc_d;
      sc_q  <= sc_d;
      cyc_q <= cyc_d;
      stl_q <= stl_d;
    end
  end

  assign cycle_count = cyc_q;
  assign stall_count = stl_q;
`endif

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: table of passes checked cycle by cycle
// against a step-list model of one pass, plus reset/wrap corner cases.
module tb_matmul_sequencer;
  localparam int N  = 2;
  localparam int DC = 3;

  logic clk = 1'b0;
  logic reset, start, mem_stall;
  logic [7:0] base_w, base_a, base_out;
  logic busy, done, mem_rd_en, w_load_en, a_load_en;
  logic sa_clear, setup_valid, mem_wr_en;
  logic [7:0] mem_rd_addr, mem_wr_addr;
  logic [0:0] load_row, out_row;
`ifdef MATMUL_SEQ_PERF_EN
  logic [31:0] cycle_count, stall_count;
`endif

  always #5 clk = ~clk;

  matmul_sequencer #(.N(N), .ADDR_W(8), .DRAIN_CYC(DC)) dut (
    .clk(clk), .reset(reset), .start(start),
    .base_w(base_w), .base_a(base_a), .base_out(base_out),
    .mem_stall(mem_stall), .busy(busy), .done(done),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .w_load_en(w_load_en), .a_load_en(a_load_en),
    .load_row(load_row), .sa_clear(sa_clear),
    .setup_valid(setup_valid), .mem_wr_en(mem_wr_en),
    .mem_wr_addr(mem_wr_addr), .out_row(out_row)
`ifdef MATMUL_SEQ_PERF_EN
    , .cycle_count(cycle_count), .stall_count(stall_count)
`endif
  );

  int vecs = 0;
  int errs = 0;

  typedef enum int {K_RW, K_RA, K_CLR, K_FEED, K_DRAIN, K_WR, K_DONE, K_NONE} kind_t;
  typedef struct {
    kind_t      k;
    logic [7:0] addr;
    int         row;
  } step_t;
  typedef struct {
    logic [7:0] bw, ba, bo;
    int         mode;
    bit         junk;
    int         exp_busy;
  } vec_t;

  step_t steps[$];
  vec_t  tbl[10];

  function automatic logic [25:0] pack_act();
    return {busy, done, mem_rd_en, w_load_en, a_load_en, sa_clear,
            setup_valid, mem_wr_en, load_row, out_row,
            mem_rd_addr, mem_wr_addr};
  endfunction

  task automatic check_vec(input string nm, input logic [25:0] exp,
                           input logic [25:0] mask);
    logic [25:0] act;
    act = pack_act();
    vecs++;
    if ((act & mask) !== (exp & mask)) begin
      errs++;
      $display("FAIL %s t=%0t: got %h want %h (mask %h)",
               nm, $time, act & mask, exp & mask, mask);
    end
  endtask

  task automatic check_int(input string nm, input longint got,
                           input longint want);
    vecs++;
    if (got != want) begin
      errs++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  // One pass as the ordered list of things the sequencer must do.
  task automatic build(input logic [7:0] bw, input logic [7:0] ba,
                       input logic [7:0] bo);
    step_t s;
    steps.delete();
    for (int k = 0; k < N; k++) begin
      s = '{K_RW, 8'(bw + k), k}; steps.push_back(s);
    end
    for (int k = 0; k < N; k++) begin
      s = '{K_RA, 8'(ba + k), k}; steps.push_back(s);
    end
    s = '{K_CLR, 8'h0, 0}; steps.push_back(s);
    for (int k = 0; k < 2 * N - 1; k++) begin
      s = '{K_FEED, 8'h0, 0}; steps.push_back(s);
    end
    for (int k = 0; k < DC; k++) begin
      s = '{K_DRAIN, 8'h0, 0}; steps.push_back(s);
    end
    for (int k = 0; k < N; k++) begin
      s = '{K_WR, 8'(bo + k), k}; steps.push_back(s);
    end
    s = '{K_DONE, 8'h0, 0}; steps.push_back(s);
  endtask

  function automatic bit is_mem(input kind_t k);
    return (k == K_RW) || (k == K_RA) || (k == K_WR);
  endfunction

  task automatic run_pass(input vec_t v, input int id);
    int idx, cyc, bubbles, dut_busy, hold, eb, prow;
    bit bub, pstall;
    kind_t pk;
    step_t s;
    logic [25:0] exp, mask;
    build(v.bw, v.ba, v.bo);
    start = 1'b1; mem_stall = 1'b0;
    base_w = v.bw; base_a = v.ba; base_out = v.bo;
    @(negedge clk);
    check_vec($sformatf("idle_before_%0d", id), 26'h0, 26'h3 << 24);
    @(posedge clk); #1;
    start = 1'b0;
    base_w = 8'($urandom); base_a = 8'($urandom); base_out = 8'($urandom);
    idx = 0; cyc = 0; bubbles = 0; dut_busy = 0; hold = 0;
    pstall = 1'b0; pk = K_NONE; prow = 0;
    while (idx < steps.size() && cyc < 100) begin
      s = steps[idx];
      bub = pstall && is_mem(s.k);
      unique case (v.mode)
        1: mem_stall = ($urandom_range(0, 3) == 0);
        2: mem_stall = (s.k == K_FEED);
        3: begin
          if (!bub && s.k == K_RA && s.row == 0) hold = 2;
          mem_stall = (hold > 0);
          if (hold > 0) hold--;
        end
        default: mem_stall = 1'b0;
      endcase
      start = v.junk && (s.k == K_FEED || s.k == K_DONE);
      if (start) begin
        base_w = 8'hE0; base_a = 8'hE4; base_out = 8'hE8;
      end
      exp = {1'b1, s.k == K_DONE, !bub && (s.k == K_RW || s.k == K_RA),
             pk == K_RW, pk == K_RA, s.k == K_CLR, s.k == K_FEED,
             !bub && s.k == K_WR, 1'(prow), 1'(s.row), s.addr, s.addr};
      mask = {8'hFF, (pk == K_RW || pk == K_RA), s.k == K_WR,
              {8{s.k == K_RW || s.k == K_RA}}, {8{s.k == K_WR}}};
      @(negedge clk);
      if (busy) dut_busy++;
      check_vec($sformatf("pass%0d_cyc%0d", id, cyc), exp, mask);
      @(posedge clk); #1;
      pk = (!bub && (s.k == K_RW || s.k == K_RA)) ? s.k : K_NONE;
      prow = s.row;
      if (bub) bubbles++;
      else idx++;
      pstall = mem_stall;
      cyc++;
    end
    start = 1'b0; mem_stall = 1'b0;
    if (cyc >= 100) begin
      vecs++; errs++;
      $display("FAIL pass%0d_timeout: got %0d cycles want <100", id, cyc);
    end
    eb = (v.exp_busy != 0) ? v.exp_busy : steps.size() + bubbles;
    check_int($sformatf("pass%0d_busy_cycles", id), dut_busy, eb);
`ifdef MATMUL_SEQ_PERF_EN
    check_int($sformatf("pass%0d_cycle_count", id), cycle_count, eb);
    check_int($sformatf("pass%0d_stall_count", id), stall_count, bubbles);
`endif
  endtask

  initial begin
    int n, bad;
    vec_t rv;
    tbl[0] = '{8'd10, 8'd20, 8'd30, 0, 1'b0, 14};
    tbl[1] = '{8'd10, 8'd20, 8'd30, 3, 1'b0, 16};
    tbl[2] = '{8'd10, 8'd20, 8'd30, 2, 1'b0, 14};
    tbl[3] = '{8'd40, 8'd50, 8'd60, 0, 1'b1, 14};
    tbl[4] = '{8'd70, 8'd80, 8'd90, 0, 1'b0, 14};
    tbl[5] = '{8'hFF, 8'hFE, 8'hFF, 0, 1'b0, 14};
    for (int i = 6; i < 10; i++)
      tbl[i] = '{8'($urandom), 8'($urandom), 8'($urandom), 1, 1'b0, 0};

    reset = 1'b1; start = 1'b1; mem_stall = 1'b1;
    base_w = 8'h55; base_a = 8'h66; base_out = 8'h77;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_vec("reset_state", 26'h0, '1);
`ifdef MATMUL_SEQ_PERF_EN
    check_int("reset_cycle_count", cycle_count, 0);
`endif
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0; mem_stall = 1'b0;

    for (int i = 0; i < 10; i++) run_pass(tbl[i], i);

    start = 1'b1; base_w = 8'd1; base_a = 8'd2; base_out = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(mem_wr_en && mem_wr_addr == 8'd3) && n < 40);
    check_int("reach_write_row0", (n < 40) ? 1 : 0, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_vec("reset_mid_pass", 26'h0, '1);
`ifdef MATMUL_SEQ_PERF_EN
    check_int("reset_mid_cycle_count", cycle_count, 0);
`endif
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy || done) bad++;
    end
    check_int("no_done_after_reset", bad, 0);
    @(posedge clk); #1;

    rv = '{8'd10, 8'd20, 8'd30, 0, 1'b0, 14};
    run_pass(rv, 10);
    rv = '{8'h00, 8'h80, 8'hFF, 0, 1'b0, 14};
    run_pass(rv, 11);

    @(negedge clk);
    check_vec("idle_final", 26'h0, 26'h3 << 24);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
